// File: rtl/seg_chain_controller.sv
// Serialises one frame MSB-first into a 74HC595-style chain, then pulses the storage latch.
// Start/busy/done handshake; o_data_clock half-period and latch width are parameterised.
module seg_chain_controller #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned LATCH_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_value,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_data_val,
  output logic                  o_data_clock,
  output logic                  o_latch
);

  localparam int unsigned MaxDiv = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxDiv) + 1;
  localparam int unsigned IdxW   = $clog2(DATA_WIDTH) + 1;

  localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] LatchLast = CntW'(LATCH_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxTop    = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StLatch,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic data_q, data_d;
  logic sclk_q, sclk_d;
  logic latch_q, latch_d;

  // State register; outputs are registered from next-state so they line up with the state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= 1'b0;
      sclk_q   <= 1'b0;
      latch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
      sclk_q   <= sclk_d;
      latch_q  <= latch_d;
    end
  end

  // Next-state logic. The shadow is shifted left per bit, so its MSB is always the bit
  // at the current index.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        cnt_d = '0;
        if (i_start) begin
          shadow_d = i_value;
          idx_d    = IdxTop;
          state_d  = StShiftLo;
        end else begin
          state_d  = StIdle;
        end
      end
      StShiftLo: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          state_d = StShiftHi;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      StShiftHi: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = StLatch;
          end else begin
            idx_d    = idx_q - IdxW'(1);
            shadow_d = shadow_q << 1;
            state_d  = StShiftLo;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLatch: begin
        if (cnt_q == LatchLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    data_d  = 1'b0;
    sclk_d  = 1'b0;
    latch_d = 1'b0;
    unique case (state_d)
      StShiftLo: begin
        busy_d = 1'b1;
        data_d = shadow_d[DATA_WIDTH-1];
      end
      StShiftHi: begin
        busy_d = 1'b1;
        sclk_d = 1'b1;
        data_d = shadow_d[DATA_WIDTH-1];
      end
      StLatch: begin
        busy_d  = 1'b1;
        latch_d = 1'b1;
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_data_val   = data_q;
  assign o_data_clock = sclk_q;
  assign o_latch      = latch_q;

endmodule
